// File: rtl/cd_sector_responder_if.sv
// CDIC sector-request bus plus the image-source read port, bundled for the responder.
// slave = responder side, master = cdic / image backend side.
interface cd_sector_responder_if;
   logic [31:0] cd_hps_lba;
   logic        cd_hps_req;
   logic        cd_hps_ack;
   logic        cd_hps_data_valid;
   logic [15:0] cd_hps_data;
   logic [31:0] src_addr;
   logic        src_rd;
   logic        src_valid;
   logic [15:0] src_data;
   logic        busy;
   logic        err_timeout;

   modport slave (
      input  cd_hps_lba, cd_hps_req, src_valid, src_data,
      output cd_hps_ack, cd_hps_data_valid, cd_hps_data, src_addr, src_rd, busy, err_timeout
   );

   modport master (
      output cd_hps_lba, cd_hps_req, src_valid, src_data,
      input  cd_hps_ack, cd_hps_data_valid, cd_hps_data, src_addr, src_rd, busy, err_timeout
   );
endinterface

// File: rtl/cd_sector_responder.sv
// Services CDIC sector requests: acks, fetches SECTOR_WORDS words from the image source
// one at a time and streams them back, substituting zero for any word that times out.
module cd_sector_responder #(
   parameter int SECTOR_WORDS = 1176,
   parameter int WORD_GAP     = 4,
   parameter int TIMEOUT      = 1023
) (
   input logic                  clk30,
   input logic                  reset_n,
   cd_sector_responder_if.slave bus
);
   localparam int WW = 11;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int GW = (WORD_GAP > 1) ? $clog2(WORD_GAP) : 1;
   localparam logic [WW-1:0] WIDX_LAST = WW'(SECTOR_WORDS - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST  = GW'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_GAP} state_t;

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic            pend_q, pend_d;
   logic [31:0]     lba_pend_q, lba_pend_d;
   logic [31:0]     base_q, base_d;
   logic [WW-1:0]   widx_q, widx_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic [15:0]     data_q, data_d;
   logic            err_q, err_d;
   logic            ack_q, ack_d;
   logic            dv_q, dv_d;
   logic            rd_q, rd_d;
   logic [31:0]     addr_q, addr_d;
   logic            busy_q, busy_d;
   logic            rise;

   always_comb begin
      state_d    = state_q;
      req_d      = bus.cd_hps_req;
      pend_d     = pend_q;
      lba_pend_d = lba_pend_q;
      base_d     = base_q;
      widx_d     = widx_q;
      tcnt_d     = tcnt_q;
      gcnt_d     = gcnt_q;
      data_d     = data_q;
      err_d      = err_q;
      ack_d      = 1'b0;
      addr_d     = addr_q;
      rise       = bus.cd_hps_req & ~req_q;

      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               base_d  = lba_pend_q * 32'(SECTOR_WORDS);
               widx_d  = '0;
               ack_d   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.src_valid) begin
               data_d  = bus.src_data;
               state_d = S_EMIT;
            end else if (tcnt_q == TMO_LAST) begin
               data_d  = 16'h0000;
               err_d   = 1'b1;
               state_d = S_EMIT;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_EMIT: begin
            if (widx_q == WIDX_LAST) begin
               state_d = S_IDLE;
            end else begin
               widx_d  = widx_q + WW'(1);
               gcnt_d  = '0;
               state_d = (WORD_GAP > 0) ? S_GAP : S_ISSUE;
            end
         end
         S_GAP: begin
            if (gcnt_q == GAP_LAST) state_d = S_ISSUE;
            else                    gcnt_d  = gcnt_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // A new edge always lands in the single pending slot, even while IDLE is
      // consuming the previous one in this same cycle.
      if (rise) begin
         pend_d     = 1'b1;
         lba_pend_d = bus.cd_hps_lba;
      end

      // Strobes are registered against the next state so they line up with it.
      rd_d = (state_d == S_ISSUE);
      if (rd_d) addr_d = base_d + 32'(widx_d);
      dv_d   = (state_d == S_EMIT);
      busy_d = (state_d != S_IDLE) | pend_d;
   end

   always_ff @(posedge clk30 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         pend_q     <= 1'b0;
         lba_pend_q <= '0;
         base_q     <= '0;
         widx_q     <= '0;
         tcnt_q     <= '0;
         gcnt_q     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         ack_q      <= 1'b0;
         dv_q       <= 1'b0;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         pend_q     <= pend_d;
         lba_pend_q <= lba_pend_d;
         base_q     <= base_d;
         widx_q     <= widx_d;
         tcnt_q     <= tcnt_d;
         gcnt_q     <= gcnt_d;
         data_q     <= data_d;
         err_q      <= err_d;
         ack_q      <= ack_d;
         dv_q       <= dv_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.cd_hps_ack        = ack_q;
   assign bus.cd_hps_data_valid = dv_q;
   assign bus.cd_hps_data       = data_q;
   assign bus.src_addr          = addr_q;
   assign bus.src_rd            = rd_q;
   assign bus.busy              = busy_q;
   assign bus.err_timeout       = err_q;
endmodule
